// File: rtl/srec_dumper_if.sv
// Bundle of the memory-read bus, character stream and dump control signals
// shared between the S-record dumper and the blocks around it.
interface srec_dumper_if;
  logic        start;
  logic [0:31] base_addr;
  logic [0:15] word_count;
  logic [0:31] mem_addr;
  logic        mem_write_en;
  logic [0:1]  mem_access_size;
  logic [0:31] mem_data_out;
  logic [0:7]  char_out;
  logic        char_valid;
  logic        char_ready;
  logic        busy;
  logic        done;

  modport master (
    input  start, base_addr, word_count, mem_data_out, char_ready,
    output mem_addr, mem_write_en, mem_access_size, char_out, char_valid, busy, done
  );

  modport slave (
    output start, base_addr, word_count, mem_data_out, char_ready,
    input  mem_addr, mem_write_en, mem_access_size, char_out, char_valid, busy, done
  );
endinterface

// File: rtl/srec_dumper.sv
// Reads word_count words from memory starting at base_addr and streams them out
// as Motorola S3 records, optionally followed by an S7 termination record.
module srec_dumper #(
  parameter logic [7:0] EOL_CHAR  = 8'h0A,
  parameter bit         S7_ENABLE = 1'b1
) (
  input logic           clk,
  input logic           reset,
  srec_dumper_if.master bus
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_FETCH, ST_WAIT, ST_EMIT, ST_TERM, ST_DONE
  } state_t;

  localparam logic [7:0] CH_S      = 8'h53;
  localparam logic [4:0] S3_LAST   = 5'd22;
  localparam logic [4:0] S7_LAST   = 5'd14;

  state_t      r_state;
  logic [0:31] r_base;
  logic [0:31] r_addr;
  logic [0:15] r_count;
  logic [0:31] r_data;
  logic [4:0]  r_idx;
  logic [0:31] r_mem_addr;
  logic [0:7]  r_char_out;
  logic        r_char_valid;
  logic        r_busy;
  logic        r_done;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  function automatic logic [7:0] byte_sum(input logic [31:0] v);
    return v[31:24] + v[23:16] + v[15:8] + v[7:0];
  endfunction

  // Character at position idx of "S309 AAAAAAAA DDDDDDDD CC EOL" (no spaces).
  function automatic logic [7:0] s3_char(input logic [4:0] idx, input logic [31:0] addr,
                                         input logic [31:0] data);
    logic [7:0]  sum;
    logic [71:0] hex;
    int          sh;
    sum = 8'h09 + byte_sum(addr) + byte_sum(data);
    hex = {addr, data, ~sum};
    sh  = 68 - 4 * (int'(idx) - 4);
    case (idx)
      5'd0:    return CH_S;
      5'd1:    return 8'h33;
      5'd2:    return 8'h30;
      5'd3:    return 8'h39;
      S3_LAST: return EOL_CHAR;
      default: return (sh >= 0 && sh <= 68) ? hex_ascii(hex[sh +: 4]) : 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] s7_char(input logic [4:0] idx, input logic [31:0] base);
    logic [7:0]  sum;
    logic [39:0] hex;
    int          sh;
    sum = 8'h05 + byte_sum(base);
    hex = {base, ~sum};
    sh  = 36 - 4 * (int'(idx) - 4);
    case (idx)
      5'd0:    return CH_S;
      5'd1:    return 8'h37;
      5'd2:    return 8'h30;
      5'd3:    return 8'h35;
      S7_LAST: return EOL_CHAR;
      default: return (sh >= 0 && sh <= 36) ? hex_ascii(hex[sh +: 4]) : 8'h00;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_base       <= '0;
      r_addr       <= '0;
      r_count      <= '0;
      r_data       <= '0;
      r_idx        <= '0;
      r_mem_addr   <= '0;
      r_char_out   <= '0;
      r_char_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_base  <= bus.base_addr;
            r_addr  <= bus.base_addr;
            r_count <= bus.word_count;
            r_busy  <= 1'b1;
            if (bus.word_count != 16'd0) begin
              r_mem_addr <= bus.base_addr;
              r_state    <= ST_FETCH;
            end else if (S7_ENABLE) begin
              r_state      <= ST_TERM;
              r_idx        <= '0;
              r_char_out   <= CH_S;
              r_char_valid <= 1'b1;
            end else begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        ST_FETCH: r_state <= ST_WAIT;
        ST_WAIT: begin
          r_data       <= bus.mem_data_out;
          r_idx        <= '0;
          r_char_out   <= CH_S;
          r_char_valid <= 1'b1;
          r_state      <= ST_EMIT;
        end
        ST_EMIT: begin
          if (bus.char_ready) begin
            if (r_idx == S3_LAST) begin
              r_addr  <= r_addr + 32'd4;
              r_count <= r_count - 16'd1;
              r_idx   <= '0;
              // r_count still holds the pre-decrement value here
              if (r_count != 16'd1) begin
                r_mem_addr   <= r_addr + 32'd4;
                r_char_valid <= 1'b0;
                r_state      <= ST_FETCH;
              end else if (S7_ENABLE) begin
                r_char_out <= CH_S;
                r_state    <= ST_TERM;
              end else begin
                r_char_valid <= 1'b0;
                r_done       <= 1'b1;
                r_state      <= ST_DONE;
              end
            end else begin
              r_idx      <= r_idx + 5'd1;
              r_char_out <= s3_char(r_idx + 5'd1, r_addr, r_data);
            end
          end
        end
        ST_TERM: begin
          if (bus.char_ready) begin
            if (r_idx == S7_LAST) begin
              r_idx        <= '0;
              r_char_valid <= 1'b0;
              r_done       <= 1'b1;
              r_state      <= ST_DONE;
            end else begin
              r_idx      <= r_idx + 5'd1;
              r_char_out <= s7_char(r_idx + 5'd1, r_base);
            end
          end
        end
        ST_DONE: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.mem_addr        = r_mem_addr;
  assign bus.mem_write_en    = 1'b0;
  assign bus.mem_access_size = 2'b11;
  assign bus.char_out        = r_char_out;
  assign bus.char_valid      = r_char_valid;
  assign bus.busy            = r_busy;
  assign bus.done            = r_done;

endmodule

// File: tb/tb_srec_dumper.sv
// Random and directed dumps of the S-record dumper, checked against a string-level
// model of the expected record stream built from a synthetic memory.
module tb_srec_dumper;
  logic clk = 1'b0;
  logic reset;

  srec_dumper_if ifc ();

  srec_dumper #(.EOL_CHAR(8'h0A), .S7_ENABLE(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  logic [31:0] key;
  bit          fixed_en;
  byte unsigned exp_q[$];
  byte unsigned got_q[$];
  logic [31:0] ma_q[$];
  logic [31:0] last_ma;
  int          done_cnt;
  int          rdy_mode;
  int          stall_left;

  // Synthetic memory: a keyed hash of the address, plus one fixed word.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (fixed_en && a == 32'h80020000) return 32'h27BDFFE8;
    return (a * 32'h9E3779B1) ^ key;
  endfunction

  always @(posedge clk) ifc.mem_data_out <= mem_word(ifc.mem_addr);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int bsum(input logic [31:0] v);
    return int'(v[31:24]) + int'(v[23:16]) + int'(v[15:8]) + int'(v[7:0]);
  endfunction

  function automatic void push_str(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
  endfunction

  function automatic void push_hex(input logic [31:0] v, input int n);
    string hd;
    hd = "0123456789ABCDEF";
    for (int i = n - 1; i >= 0; i--) exp_q.push_back(hd[int'((v >> (4 * i)) & 32'hF)]);
  endfunction

  function automatic void build_exp(input logic [31:0] base, input int cnt);
    logic [31:0] a;
    logic [31:0] d;
    exp_q.delete();
    a = base;
    for (int w = 0; w < cnt; w++) begin
      d = mem_word(a);
      push_str("S309");
      push_hex(a, 8);
      push_hex(d, 8);
      push_hex(32'((~(9 + bsum(a) + bsum(d))) & 255), 2);
      exp_q.push_back(8'h0A);
      a = a + 32'd4;
    end
    push_str("S705");
    push_hex(base, 8);
    push_hex(32'((~(5 + bsum(base))) & 255), 2);
    exp_q.push_back(8'h0A);
  endfunction

  // One clock: sample at the falling edge, drive char_ready just after the rising edge.
  task automatic tick();
    @(negedge clk);
    if (ifc.char_valid && ifc.char_ready) got_q.push_back(ifc.char_out);
    if (ifc.done) done_cnt++;
    if (ifc.mem_addr !== last_ma) begin
      ma_q.push_back(ifc.mem_addr);
      last_ma = ifc.mem_addr;
    end
    if (rdy_mode == 2 && ifc.char_ready === 1'b0) begin
      check("stall_char", 32'(ifc.char_out), 32'h39);
      check("stall_valid", 32'(ifc.char_valid), 32'd1);
    end
    @(posedge clk);
    #1;
    case (rdy_mode)
      0: ifc.char_ready = 1'b1;
      1: ifc.char_ready = ($urandom_range(0, 3) != 0);
      default: begin
        if (got_q.size() == 3 && stall_left > 0) begin
          ifc.char_ready = 1'b0;
          stall_left--;
        end else begin
          ifc.char_ready = 1'b1;
        end
      end
    endcase
  endtask

  task automatic cmp_stream(input string tag);
    check({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check($sformatf("%s_ch%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
      if (got_q[i] !== exp_q[i]) break;
    end
  endtask

  task automatic run_dump(input logic [31:0] base, input int cnt, input int mode,
                          input int restart_at, input string tag);
    int n;
    build_exp(base, cnt);
    got_q.delete();
    ma_q.delete();
    last_ma    = ifc.mem_addr;
    done_cnt   = 0;
    rdy_mode   = mode;
    stall_left = 5;
    ifc.base_addr  = base;
    ifc.word_count = 16'(cnt);
    ifc.start      = 1'b1;
    tick();
    ifc.start      = 1'b0;
    ifc.base_addr  = $urandom;
    ifc.word_count = 16'($urandom_range(1, 9));
    n = 0;
    while (done_cnt == 0 && n < 3000) begin
      n++;
      ifc.start = (n == restart_at);
      tick();
    end
    ifc.start = 1'b0;
    tick();
    check({tag, "_done"}, 32'(done_cnt), 32'd1);
    check({tag, "_busy"}, 32'(ifc.busy), 32'd0);
    cmp_stream(tag);
    $display("dump %s base=%08h count=%0d chars=%0d", tag, base, cnt, got_q.size());
  endtask

  task automatic cmp_literal(input string tag, input string s);
    check({tag, "_litlen"}, 32'(got_q.size()), 32'(s.len()));
    for (int i = 0; i < s.len() && i < got_q.size(); i++) begin
      check($sformatf("%s_lit%0d", tag, i), 32'(got_q[i]), 32'(s[i]));
      if (got_q[i] !== s[i]) break;
    end
  endtask

  initial begin
    int n;
    key             = $urandom;
    fixed_en        = 1'b1;
    reset           = 1'b1;
    ifc.start       = 1'b0;
    ifc.base_addr   = '0;
    ifc.word_count  = '0;
    ifc.char_ready  = 1'b0;
    rdy_mode        = 0;
    last_ma         = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_valid", 32'(ifc.char_valid), 32'd0);
    check("rst_char", 32'(ifc.char_out), 32'd0);
    check("rst_busy", 32'(ifc.busy), 32'd0);
    check("rst_done", 32'(ifc.done), 32'd0);
    check("rst_maddr", ifc.mem_addr, 32'd0);
    check("mem_we", 32'(ifc.mem_write_en), 32'd0);
    check("mem_size", 32'(ifc.mem_access_size), 32'd3);

    run_dump(32'h80020000, 0, 0, 0, "s7only");
    cmp_literal("s7only", "S7058002000078\n");
    check("s7only_noread", ifc.mem_addr, 32'd0);

    run_dump(32'h80020000, 1, 0, 0, "known");
    cmp_literal("known", "S3098002000027BDFFE8A9\nS7058002000078\n");

    run_dump(32'h80020000, 1, 2, 0, "stall");
    check("stall_cycles", 32'(stall_left), 32'd0);

    run_dump(32'hFFFFFFFC, 2, 0, 0, "wrap");
    check("wrap_nread", 32'(ma_q.size()), 32'd2);
    if (ma_q.size() == 2) begin
      check("wrap_a0", ma_q[0], 32'hFFFFFFFC);
      check("wrap_a1", ma_q[1], 32'h00000000);
    end

    fixed_en = 1'b0;
    for (int k = 0; k < 6; k++) run_dump($urandom, $urandom_range(0, 4), 1, 0, $sformatf("rnd%0d", k));

    run_dump($urandom, 3, 1, 20, "restart");

    // Reset while the 10th character of the first S3 record is presented.
    got_q.delete();
    rdy_mode       = 0;
    ifc.base_addr  = $urandom;
    ifc.word_count = 16'd1;
    ifc.start      = 1'b1;
    tick();
    ifc.start = 1'b0;
    n = 0;
    while (got_q.size() < 9 && n < 200) begin
      n++;
      tick();
    end
    check("midrst_reached", 32'(got_q.size()), 32'd9);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("midrst_valid", 32'(ifc.char_valid), 32'd0);
    check("midrst_busy", 32'(ifc.busy), 32'd0);
    check("midrst_done", 32'(ifc.done), 32'd0);
    run_dump($urandom, 1, 1, 0, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
